// File: rtl/temperature_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : temperature_scan_ctrl_if
// Brief    : Request/result bundle between a scan requester and the
//            temperature scan controller.
// Revision : 1.0 - initial release
// ============================================================================
interface temperature_scan_ctrl_if #(
  parameter int NR_SENSORS = 200
);
  logic                      start_i;
  logic [8*NR_SENSORS-1:0]   sensors_data_i;
  logic [NR_SENSORS-1:0]     sensors_en_i;
  logic                      busy_o;
  logic                      valid_o;
  logic [7:0]                avg_o;
  logic [7:0]                active_cnt_o;
  logic                      alert_o;

  modport master (
    output start_i, sensors_data_i, sensors_en_i,
    input  busy_o, valid_o, avg_o, active_cnt_o, alert_o
  );

  modport slave (
    input  start_i, sensors_data_i, sensors_en_i,
    output busy_o, valid_o, avg_o, active_cnt_o, alert_o
  );
endinterface
`default_nettype wire

// File: rtl/temperature_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : temperature_scan_ctrl
// Brief    : Snapshots all sensors, accumulates enabled readings one per clock,
//            then a 16-step restoring divide yields a rounded average + alert.
// Revision : 1.0 - initial release
// ============================================================================
module temperature_scan_ctrl #(
  parameter int NR_SENSORS = 200,
  parameter int TEMP_MIN   = 19,
  parameter int TEMP_MAX   = 26
) (
  input  wire logic                clk_i,
  input  wire logic                rst_n_i,
  temperature_scan_ctrl_if.slave   bus
);

  localparam int                 c_idx_w    = (NR_SENSORS > 1) ? $clog2(NR_SENSORS) : 1;
  localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(NR_SENSORS - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SCAN   = 2'd1,
    S_DIVIDE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 w_busy;
  logic                 w_valid;

  logic [7:0]           r_snap_data [NR_SENSORS];
  logic [NR_SENSORS-1:0] r_snap_en;
  logic [c_idx_w-1:0]   r_idx;
  // Accumulator while scanning; reused as the dividend/quotient shifter.
  logic [15:0]          r_sum;
  logic [7:0]           r_cnt;
  logic [8:0]           r_rem;
  logic [3:0]           r_div_iter;
  logic [7:0]           r_avg;
  logic [7:0]           r_active_cnt;
  logic                 r_alert;

  logic                 w_accept;
  logic                 w_last_idx;
  logic                 w_last_iter;
  logic [9:0]           w_rem_shift;
  logic [9:0]           w_rem_diff;
  logic                 w_q_bit;
  logic [9:0]           w_rem_nxt;
  logic [15:0]          w_quo_nxt;
  logic                 w_round_up;
  logic [15:0]          w_avg_full;
  logic                 w_alert_calc;

  assign w_accept    = (r_state == S_IDLE) && bus.start_i;
  assign w_last_idx  = (r_idx == c_last_idx);
  assign w_last_iter = (r_div_iter == 4'd15);

  // One restoring step: shift the next dividend bit into the remainder.
  assign w_rem_shift = {r_rem, r_sum[15]};
  assign w_rem_diff  = w_rem_shift - {2'b00, r_cnt};
  assign w_q_bit     = (w_rem_shift >= {2'b00, r_cnt});
  assign w_rem_nxt   = w_q_bit ? w_rem_diff : w_rem_shift;
  assign w_quo_nxt   = {r_sum[14:0], w_q_bit};

  // Round half up: add one when twice the final remainder reaches the divisor.
  assign w_round_up   = ({w_rem_nxt, 1'b0} >= {3'b000, r_cnt});
  assign w_avg_full   = w_quo_nxt + {15'd0, w_round_up};
  assign w_alert_calc = (w_avg_full < 16'(TEMP_MIN)) || (w_avg_full > 16'(TEMP_MAX));

  generate
    for (genvar gi = 0; gi < NR_SENSORS; gi++) begin : g_snap
      always_ff @(posedge clk_i) begin
        if (w_accept) begin
          r_snap_data[gi] <= bus.sensors_data_i[8*gi +: 8];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (w_accept) begin
      r_snap_en <= bus.sensors_en_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    w_valid     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start_i) begin
          w_state_nxt = S_SCAN;
        end
      end
      S_SCAN: begin
        w_busy = 1'b1;
        if (w_last_idx) begin
          w_state_nxt = S_DIVIDE;
        end
      end
      S_DIVIDE: begin
        w_busy = 1'b1;
        if (w_last_iter) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_valid     = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_idx        <= '0;
      r_sum        <= '0;
      r_cnt        <= '0;
      r_rem        <= '0;
      r_div_iter   <= '0;
      r_avg        <= '0;
      r_active_cnt <= '0;
      r_alert      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start_i) begin
            r_idx      <= '0;
            r_sum      <= '0;
            r_cnt      <= '0;
            r_rem      <= '0;
            r_div_iter <= '0;
          end
        end
        S_SCAN: begin
          if (r_snap_en[r_idx]) begin
            r_sum <= r_sum + {8'd0, r_snap_data[r_idx]};
            r_cnt <= r_cnt + 8'd1;
          end
          r_idx <= w_last_idx ? '0 : r_idx + 1'b1;
        end
        S_DIVIDE: begin
          r_sum      <= w_quo_nxt;
          r_rem      <= w_rem_nxt[8:0];
          r_div_iter <= r_div_iter + 4'd1;
          if (w_last_iter) begin
            r_active_cnt <= r_cnt;
            // With no active sensor the quotient is meaningless.
            if (r_cnt == 8'd0) begin
              r_avg   <= 8'd0;
              r_alert <= 1'b1;
            end else begin
              r_avg   <= w_avg_full[7:0];
              r_alert <= w_alert_calc;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.busy_o       = w_busy;
  assign bus.valid_o      = w_valid;
  assign bus.avg_o        = r_avg;
  assign bus.active_cnt_o = r_active_cnt;
  assign bus.alert_o      = r_alert;

endmodule
`default_nettype wire
